load_store_unit: RTL and testbench

- Multi-cycle access controller between the datapath memory stage and the word-organised DataMemory.
- Accepts byte, halfword and word load/store requests from the core and converts them into 32-bit word reads and writes.
- Sub-word stores use read-modify-write. Sub-word loads are sign- or zero-extended.
- Returns load data and a misalignment error flag to the write-back path.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response and DataMemory-side signals of the load/store unit.
// The master modport is the environment (core plus memory); the slave modport is the unit.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic [31:0]           mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store controller: byte/halfword/word requests mapped onto a
// 32-bit word memory, read-modify-write for sub-word stores, extended sub-word loads.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int READ_WAIT  = 0
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT);

    state_t                state_r;
    state_t                next_state_s;
    logic                  accept_s;
    logic                  misalign_s;
    logic                  read_done_s;
    logic [7:0]            wait_cnt_r;
    logic                  we_r;
    logic                  signed_r;
    logic [1:0]            size_r;
    logic [1:0]            off_r;
    logic [31:0]           wdata_r;
    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic                  resp_err_r;
    logic [31:0]           resp_rdata_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_wdata_r;
    logic                  mem_we_r;

    // Little-endian lane extraction with optional sign extension; words pass through.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the right-aligned store data.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign accept_s    = (state_r == IDLE) && bus.req_valid;
    assign read_done_s = (wait_cnt_r == WAIT_LAST);

    // Alignment/size legality of the presented request.
    always_comb begin
        misalign_s = 1'b0;
        case (bus.req_size)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = bus.req_addr[0];
            2'b10:   misalign_s = (bus.req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; only the error path goes straight from IDLE to RESP.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    next_state_s = IDLE;
                end else if (misalign_s) begin
                    next_state_s = RESP;
                end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                    next_state_s = WRITE;
                end else begin
                    next_state_s = READ;
                end
            end
            READ: begin
                if (!read_done_s) begin
                    next_state_s = READ;
                end else if (we_r) begin
                    next_state_s = WRITE;
                end else begin
                    next_state_s = RESP;
                end
            end
            WRITE:   next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Request capture at acceptance and the READ dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r       <= 1'b0;
            signed_r   <= 1'b0;
            size_r     <= 2'b00;
            off_r      <= 2'b00;
            wdata_r    <= 32'd0;
            wait_cnt_r <= 8'd0;
        end else begin
            if (accept_s) begin
                we_r     <= bus.req_we;
                signed_r <= bus.req_signed;
                size_r   <= bus.req_size;
                off_r    <= bus.req_addr[1:0];
                wdata_r  <= bus.req_wdata;
            end
            if ((state_r == READ) && !read_done_s) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
        end
    end

    // Registered outputs, loaded from the upcoming state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
            mem_we_r     <= 1'b0;
        end else begin
            req_ready_r  <= (next_state_s == IDLE);
            resp_valid_r <= (next_state_s == RESP);
            resp_err_r   <= (state_r == IDLE) && (next_state_s == RESP);
            mem_we_r     <= (next_state_s == WRITE);
            if (accept_s && !misalign_s) begin
                mem_addr_r <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
            if ((state_r == IDLE) && (next_state_s == WRITE)) begin
                mem_wdata_r <= bus.req_wdata;
            end else if ((state_r == READ) && (next_state_s == WRITE)) begin
                mem_wdata_r <= merge(bus.mem_rdata, wdata_r, size_r, off_r);
            end
            if ((state_r == READ) && (next_state_s == RESP)) begin
                resp_rdata_r <= extract(bus.mem_rdata, size_r, off_r, signed_r);
            end else if (next_state_s == RESP) begin
                resp_rdata_r <= 32'd0;
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_we     = mem_we_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts
// every response and memory write; monitors compare whenever the unit presents them.
module tb_load_store_unit;
    localparam int RW = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_load = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    resp_t       rq[$];
    wr_t         wq[$];
    resp_t       got_r;
    wr_t         got_w;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus();

    load_store_unit #(.ADDR_WIDTH(32), .READ_WAIT(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DataMemory: combinational read, synchronous write.
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                n_tests++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: resp_valid with rdata=%h err=%b at cycle %0d, required no response",
                             bus.resp_rdata, bus.resp_err, cyc);
                end else begin
                    got_r = rq.pop_front();
                    if (bus.resp_rdata !== got_r.rdata || bus.resp_err !== got_r.err || cyc != got_r.due) begin
                        n_fail++;
                        $display("FAIL resp: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                                 bus.resp_rdata, bus.resp_err, cyc, got_r.rdata, got_r.err, got_r.due);
                    end
                end
            end else if (bus.resp_err !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_err_idle: resp_err=%b outside response, required 0", bus.resp_err);
            end
        end
    end

    // Memory-write monitor: every mem_we cycle must match one predicted write.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            n_tests++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: mem_we with addr=%h data=%h, required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                got_w = wq.pop_front();
                if (bus.mem_addr !== got_w.addr || bus.mem_wdata !== got_w.data) begin
                    n_fail++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, got_w.addr, got_w.data);
                end
            end
        end
    end

    // Reference model: predicts response, latency and memory effect of one accepted request.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] v;
        int          sh;
        resp_t       r;
        wr_t         w;
        mask = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        sh   = 8 * int'(addr % 4);
        word = ref_mem[addr[9:2]];
        r.err   = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
        r.rdata = 32'd0;
        if (r.err) begin
            r.due = cyc + 1;
        end else if (!we) begin
            v = (word >> sh) & mask;
            if (sgn && size != 2'd2 && v > (mask >> 1)) v = v | ~mask;
            r.rdata = v;
            r.due   = cyc + 2 + RW;
        end else begin
            if (size == 2'd2) begin
                v     = wdata;
                r.due = cyc + 2;
            end else begin
                v     = (word & ~(mask << sh)) | ((wdata & mask) << sh);
                r.due = cyc + 3 + RW;
            end
            w.addr = addr & 32'hFFFF_FFFC;
            w.data = v;
            wq.push_back(w);
            ref_mem[addr[9:2]] = v;
        end
        rq.push_back(r);
    endtask

    // Present a request (called at a negedge), wait bounded for acceptance, leave req_valid high.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int waited = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.req_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
            bus.req_valid = 1'b0;
            return;
        end
        model(we, size, sgn, addr, wdata);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until every predicted response and write has been observed.
    task automatic drain();
        int waited = 0;
        bus.req_valid = 1'b0;
        while ((rq.size() != 0 || wq.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (rq.size() != 0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses and %0d writes outstanding, required 0 and 0", rq.size(), wq.size());
            rq.delete();
            wq.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
            bus.resp_rdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: ready=%b rv=%b err=%b rdata=%h maddr=%h mwdata=%h mwe=%b, required 1 0 0 0 0 0 0",
                     tag, bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
                     bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'h8899_AABB;
        ref_mem[2] = 32'h1122_3344;

        // Reset held for two cycles while the memory image is loaded.
        @(negedge clk);
        mem_load = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");

        // Word loads, the first at 4, then back-to-back at 0, 8, 12, 16.
        issue(1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
        idle(3);
        issue(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'd12, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'd16, 32'd0);
        // Sub-word loads from 0x8899AABB.
        issue(1'b0, 2'b00, 1'b1, 32'd5, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 32'd5, 32'd0);
        issue(1'b0, 2'b00, 1'b1, 32'd4, 32'd0);
        issue(1'b0, 2'b01, 1'b1, 32'd6, 32'd0);
        issue(1'b0, 2'b01, 1'b0, 32'd6, 32'd0);
        // Read-modify-write stores into 0x11223344, then read back.
        issue(1'b1, 2'b00, 1'b0, 32'd10, 32'h0000_00EE);
        issue(1'b1, 2'b01, 1'b0, 32'd8, 32'h0000_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
        // Misaligned / reserved-size requests.
        issue(1'b0, 2'b01, 1'b1, 32'd3, 32'd0);
        issue(1'b1, 2'b10, 1'b0, 32'd6, 32'hDEAD_BEEF);
        issue(1'b0, 2'b11, 1'b0, 32'd0, 32'd0);
        drain();

        // Reset while a byte store sits in READ: no write may follow.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd9;
        bus.req_wdata  = 32'h0000_0077;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
        drain();

        // Randomised mix with random gaps and back-to-back holds.
        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
        end
        drain();

        // Final memory image must match the model word for word.
        for (int i = 0; i < 256; i++) begin
            n_tests++;
            if (mem[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL mem_image[%0d]: got %h, required %h", i, mem[i], ref_mem[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
